// File: rtl/codec_fifo_pkg.sv
// Shared audio definitions: sample width and codec FIFO state encoding.
package audio_defs;
  localparam int SAMPLE_WIDTH = 16;
  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1
  } fifo_state_t;
endpackage

// File: rtl/sample_fifo_ram.sv
// Register-array memory: synchronous write, combinational read, no reset.
module sample_fifo_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/codec_fifo.sv
// Elastic sample buffer between echo output and codec requests.
// Primes to PRIME_LEVEL before serving; sticky overflow/underflow.
module codec_fifo
  import audio_defs::*;
#(
  parameter int WIDTH       = SAMPLE_WIDTH,
  parameter int DEPTH_LOG2  = 3,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      sample_in,
  input  logic                  in_ready,
  input  logic                  codec_req,
  input  logic                  clear_flags,
  output logic [WIDTH-1:0]      sample_out,
  output logic                  sample_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DL = DEPTH_LOG2;
  localparam logic [DL:0] FULL = {1'b1, {DL{1'b0}}};
  localparam logic [DL:0] PRIME_L = PRIME_LEVEL[DL:0];

  fifo_state_t state, state_nxt;
  logic [DL-1:0] wr_ptr, rd_ptr;
  logic [DL:0] level_nxt;
  logic [WIDTH-1:0] rdata;
  logic full, empty;
  logic pop_fire, push, drop, starve;

  assign full  = (level == FULL);
  assign empty = (level == '0);

  sample_fifo_ram #(.WIDTH(WIDTH), .AW(DL)) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(sample_in),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= PRIME;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      PRIME: if (level_nxt >= PRIME_L) state_nxt = RUN;
      RUN:   if (starve) state_nxt = PRIME;
      default: state_nxt = PRIME;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    pop_fire  = codec_req && (state == RUN) && !empty;
    starve    = codec_req && (state == RUN) && empty;
    push      = in_ready && (!full || pop_fire);
    drop      = in_ready && full && !pop_fire;
    level_nxt = level + {{DL{1'b0}}, push} - {{DL{1'b0}}, pop_fire};
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= pop_fire;
      if (pop_fire) sample_out <= rdata;
    end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop)             overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (starve)           underflow <= 1'b1;
      else if (clear_flags) underflow <= 1'b0;
    end
endmodule

// File: tb/tb_codec_fifo.sv
// Directed self-checking bench for codec_fifo.
module tb_codec_fifo;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               in_ready = 1'b0;
  logic               codec_req = 1'b0;
  logic               clear_flags = 1'b0;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic [3:0]         level;
  logic               overflow, underflow;
  int checks = 0;
  int failures = 0;

  codec_fifo #(.WIDTH(16), .DEPTH_LOG2(3), .PRIME_LEVEL(4)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in),
    .in_ready(in_ready), .codec_req(codec_req),
    .clear_flags(clear_flags), .sample_out(sample_out),
    .sample_valid(sample_valid), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; outputs are observed 1 time unit after the edge.
  task automatic step(input logic ir, input logic signed [15:0] d,
                      input logic rq, input logic cf);
    @(negedge clk);
    in_ready = ir; sample_in = d; codec_req = rq; clear_flags = cf;
    @(posedge clk);
    #1;
    in_ready = 0; codec_req = 0; clear_flags = 0;
  endtask

  task automatic test_reset;
    #12 reset = 0;
    #1;
    checks++;
    if (level !== 4'd0 || sample_out !== 16'sd0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state level=%0d out=%0d valid=%b want 0/0/0",
               level, sample_out, sample_valid);
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags ovf=%b unf=%b want 0/0", overflow, underflow);
    end
  endtask

  task automatic test_prime;
    step(1, 16'sd100, 0, 0);
    step(0, 0, 0, 0);
    step(1, -16'sd200, 0, 0);
    step(0, 0, 0, 0);
    step(1, 16'sd300, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    checks++;
    if (sample_valid !== 1'b0 || level !== 4'd3 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL prime_ignore valid=%b level=%0d unf=%b want 0/3/0",
               sample_valid, level, underflow);
    end
    step(1, -16'sd400, 0, 0);
    checks++;
    if (level !== 4'd4 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL prime_fill level=%0d valid=%b want 4/0", level, sample_valid);
    end
  endtask

  task automatic test_drain;
    logic signed [15:0] exp [4];
    exp[0] = 16'sd100; exp[1] = -16'sd200;
    exp[2] = 16'sd300; exp[3] = -16'sd400;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (sample_valid !== 1'b1 || sample_out !== exp[i]) begin
        failures++;
        $display("FAIL drain_%0d valid=%b out=%0d want 1/%0d",
                 i, sample_valid, sample_out, exp[i]);
      end
      step(0, 0, 0, 0);
      checks++;
      if (sample_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_pulse_%0d valid=%b want 0", i, sample_valid);
      end
    end
    checks++;
    if (level !== 4'd0) begin
      failures++;
      $display("FAIL drain_level level=%0d want 0", level);
    end
  endtask

  task automatic test_underflow;
    step(0, 0, 1, 0);
    checks++;
    if (sample_valid !== 1'b0 || sample_out !== -16'sd400 || underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow valid=%b out=%0d unf=%b want 0/-400/1",
               sample_valid, sample_out, underflow);
    end
    step(0, 0, 0, 1);
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_unf unf=%b want 0", underflow);
    end
    step(0, 0, 1, 0);
    checks++;
    if (sample_valid !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reprime valid=%b unf=%b want 0/0", sample_valid, underflow);
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0);
    checks++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fill level=%0d ovf=%b want 8/0", level, overflow);
    end
    step(1, 16'sd9, 0, 1);
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow level=%0d ovf=%b want 8/1", level, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (sample_valid !== 1'b1 || sample_out !== 16'(i)) begin
        failures++;
        $display("FAIL ovf_drain_%0d valid=%b out=%0d want 1/%0d",
                 i, sample_valid, sample_out, i);
      end
    end
    step(0, 0, 0, 1);
    checks++;
    if (level !== 4'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear level=%0d ovf=%b want 0/0", level, overflow);
    end
  endtask

  task automatic test_full_simul;
    for (int i = 10; i <= 17; i++) step(1, 16'(i), 0, 0);
    step(1, 16'sd99, 1, 0);
    checks++;
    if (level !== 4'd8 || overflow !== 1'b0 || sample_valid !== 1'b1
        || sample_out !== 16'sd10) begin
      failures++;
      $display("FAIL full_simul level=%0d ovf=%b valid=%b out=%0d want 8/0/1/10",
               level, overflow, sample_valid, sample_out);
    end
    step(1, 16'sd100, 0, 0);
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL full_drop level=%0d ovf=%b want 8/1", level, overflow);
    end
    for (int i = 11; i <= 13; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (sample_out !== 16'(i)) begin
        failures++;
        $display("FAIL after_full_%0d out=%0d want %0d", i, sample_out, i);
      end
    end
  endtask

  task automatic test_async_reset;
    checks++;
    if (level !== 4'd5) begin
      failures++;
      $display("FAIL pre_reset level=%0d want 5", level);
    end
    @(negedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if (level !== 4'd0 || sample_out !== 16'sd0 || overflow !== 1'b0
        || underflow !== 1'b0) begin
      failures++;
      $display("FAIL async_reset level=%0d out=%0d ovf=%b unf=%b want 0",
               level, sample_out, overflow, underflow);
    end
    @(negedge clk);
    reset = 0;
    step(0, 0, 1, 0);
    checks++;
    if (sample_valid !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_prime valid=%b unf=%b want 0/0",
               sample_valid, underflow);
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_drain();
    test_underflow();
    test_overflow();
    test_full_simul();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/codec_fifo.md
Name: codec_fifo

Overview:
- Elastic sample buffer between the echo stage output (out/out_ready) and the audio codec's sample-request interface.
- Absorbs phase and jitter differences between echo's sample strobe and the codec's request strobe.
- Primes to a fill threshold before serving, then hands one sample per codec request.
- Reports fill level and sticky overflow/underflow flags for the debug display.

Parameters:
- WIDTH, 16, sample width (two's complement).
- DEPTH_LOG2, 3, log2 of entry count (8 entries).
- PRIME_LEVEL, 4, fill level required to leave PRIME; legal range 1..2^DEPTH_LOG2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  WIDTH  signed sample from echo `out`.
- in_ready  in  1  one-cycle strobe; sample_in valid this cycle (echo `out_ready`).
- codec_req  in  1  one-cycle strobe; codec wants the next sample.
- clear_flags  in  1  one-cycle strobe; clears the sticky flags.
- sample_out  out  WIDTH  registered sample presented to the codec.
- sample_valid  out  1  one-cycle pulse; sample_out was updated from the FIFO this cycle.
- level  out  DEPTH_LOG2+1  current number of stored entries (0..2^DEPTH_LOG2).
- overflow  out  1  sticky; a push was dropped because the FIFO was full.
- underflow  out  1  sticky; a RUN-state request found the FIFO empty.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - rd_ptr = wr_ptr = level = 0; state = PRIME.
  - sample_out = 0; sample_valid = 0; overflow = underflow = 0.
  - Memory contents are don't-care.
- Pointers: DEPTH_LOG2 bits, wrap naturally from 2^DEPTH_LOG2-1 to 0. level is a separate counter, so full (level == 2^DEPTH_LOG2) and empty (level == 0) are unambiguous.
- Push = in_ready && (level != full || pop_fire). A push writes mem[wr_ptr] and increments wr_ptr.
- If in_ready arrives while full and no pop fires that cycle: the sample is dropped, overflow is set, and wr_ptr and level are unchanged.
- pop_fire = codec_req && state == RUN && level != 0.
  - On pop_fire: sample_out <= mem[rd_ptr], rd_ptr increments, and sample_valid = 1 on the following cycle (latency 1 clk from codec_req).
  - No write-to-read bypass: an empty FIFO cannot serve a same-cycle push.
- Level update: level += push − pop_fire. A simultaneous push and pop leaves level unchanged; this is legal at both full and empty boundaries.
- State machine:
  - PRIME:
    - codec_req is ignored: sample_out holds, no sample_valid, no underflow.
    - Go to RUN at the clock edge where the updated level >= PRIME_LEVEL.
  - RUN:
    - codec_req with level != 0 -> pop as above.
    - codec_req with level == 0 -> sample_out holds its last value, underflow is set, state returns to PRIME (re-prime).
- Flags:
  - overflow and underflow are sticky until clear_flags or reset.
  - If clear_flags and a new set event occur in the same cycle, set wins.
- sample_out changes only on pop_fire or reset.
- All arithmetic is unsigned pointer/level arithmetic. Sample data passes through unmodified; no sign handling is needed.

Decomposition:
- Shared package `audio_defs`:
  - SAMPLE_WIDTH = 16.
  - Two-bit FIFO state encoding: PRIME = 0, RUN = 1.
- Sub-module `sample_fifo_ram`:
  - Register-array dual-port memory: one synchronous write port, one combinational read port.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
  - Contents are not reset.
- Pointers, level counter, FSM and flags live in `codec_fifo`, built from the existing dffr/dffre flop style but with asynchronous reset.

Test Plan:
- Reset, then push 4 samples (100, −200, 300, −400) on separated in_ready strobes -> state RUN after the 4th push; level = 4; no sample_valid yet.
- From that state, issue 4 codec_req -> sample_out = 100, −200, 300, −400 in order, each one cycle after its request, with a one-cycle sample_valid each; level ends at 0.
- Issue codec_req with level = 0 in RUN -> sample_out stays −400; underflow = 1; state PRIME. A further codec_req produces no sample_valid. Pulse clear_flags -> underflow = 0.
- Push 9 samples 1..9 with no requests -> level = 8, overflow = 1. After 8 requests, samples 1..8 emerge; 9 is dropped.
- With full FIFO (level = 8, RUN), assert in_ready and codec_req in the same cycle -> level stays 8; overflow not set; oldest sample output.
- Assert reset asynchronously mid-stream (between clock edges, level = 5) -> level, sample_out and flags read 0 before the next clk edge; state PRIME.
